// File: rtl/iref_seq.sv
// rtl/iref_seq.sv - IREF power-up/power-down bus sequencer
// Drives PD/CHARGE writes onto the IREF slave port with timeout and power-down pre-emption.
module iref_seq #(
  parameter int DATA_W      = 32,
  parameter int IREF_ADDR_W = 1,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pwrdn,
  input  logic [CNT_W-1:0]       charge_cycles,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   valid,
  output logic [IREF_ADDR_W-1:0] address,
  output logic [DATA_W-1:0]      wdata,
  output logic                   wstrb,
  input  logic                   ready
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_CHG_WAIT, S_DONE, S_ERR} state_e;
  typedef enum logic [1:0] {ST_PD0, ST_CHG1, ST_CHG0, ST_PD1} step_e;

  state_e                 state_q, state_d;
  step_e                  step_q, step_d;
  logic                   seq_pd_q, seq_pd_d;
  logic                   pend_pd_q, pend_pd_d;
  logic [CNT_W-1:0]       cc_q, cc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic                   valid_q, valid_d;
  logic [IREF_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   pd_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= ST_PD0;
      seq_pd_q  <= 1'b0;
      pend_pd_q <= 1'b0;
      cc_q      <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      seq_pd_q  <= seq_pd_d;
      pend_pd_q <= pend_pd_d;
      cc_q      <= cc_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // A latched or same-cycle pwrdn abandons power-up at the next idle-bus point
  assign pd_now = !seq_pd_q && (pend_pd_q || pwrdn);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    seq_pd_d  = seq_pd_q;
    pend_pd_d = pend_pd_q;
    cc_d      = cc_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (pwrdn) begin
          state_d   = S_WR;
          step_d    = ST_CHG0;
          seq_pd_d  = 1'b1;
          pend_pd_d = 1'b0;
          to_d      = '0;
        end else if (start) begin
          state_d   = S_WR;
          step_d    = ST_PD0;
          seq_pd_d  = 1'b0;
          pend_pd_d = 1'b0;
          cc_d      = charge_cycles;
          to_d      = '0;
        end
      end
      S_WR: begin
        pend_pd_d = pend_pd_q | (pwrdn & ~seq_pd_q);
        if (ready) begin
          to_d = '0;
          case (step_q)
            ST_PD0:  state_d = S_GAP;
            ST_CHG1: begin
              state_d = S_CHG_WAIT;
              cnt_d   = (cc_q == '0) ? CNT_W'(1) : cc_q;
            end
            ST_CHG0: state_d = seq_pd_q ? S_GAP : S_DONE;
            default: state_d = S_DONE;
          endcase
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_WR;
        to_d    = '0;
        if (pd_now) begin
          step_d    = ST_CHG0;
          seq_pd_d  = 1'b1;
          pend_pd_d = 1'b0;
        end else begin
          step_d = (step_q == ST_PD0) ? ST_CHG1 : ST_PD1;
        end
      end
      S_CHG_WAIT: begin
        if (pd_now) begin
          state_d   = S_WR;
          step_d    = ST_CHG0;
          seq_pd_d  = 1'b1;
          pend_pd_d = 1'b0;
          to_d      = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_WR;
          step_d  = ST_CHG0;
          to_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        pend_pd_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d    = (state_d == S_WR);
    addr_d     = '0;
    wdata_d    = '0;
    if (valid_d) begin
      addr_d     = (step_d == ST_CHG1 || step_d == ST_CHG0) ? IREF_ADDR_W'(1) : '0;
      wdata_d[0] = (step_d == ST_CHG1 || step_d == ST_PD1);
    end
    busy_d = (state_d == S_WR) || (state_d == S_GAP) || (state_d == S_CHG_WAIT);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  assign valid   = valid_q;
  assign wstrb   = valid_q;
  assign address = addr_q;
  assign wdata   = wdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_iref_seq.sv
// tb/tb_iref_seq.sv - directed bench for iref_seq against a model IREF slave
module tb_iref_seq;
  logic        clk, rst, start, pwrdn;
  logic [15:0] charge_cycles;
  logic        busy, done, err, valid, wstrb, ready;
  logic [0:0]  address;
  logic [31:0] wdata;

  iref_seq dut (
    .clk(clk), .rst(rst), .start(start), .pwrdn(pwrdn), .charge_cycles(charge_cycles),
    .busy(busy), .done(done), .err(err), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model IREF slave: ready registered one cycle after valid, PD resets high
  logic s_ready, s_pd, s_chg;
  bit   slave_dead;
  assign ready = s_ready;
  always @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b0;
      s_pd    <= 1'b1;
      s_chg   <= 1'b0;
    end else begin
      s_ready <= valid && !s_ready && !slave_dead;
      if (valid && s_ready) begin
        if (address == 1'b0) s_pd <= wdata[0];
        else s_chg <= wdata[0];
      end
    end
  end

  typedef struct {int addr; int data; int hi; int lo;} wr_t;
  wr_t wlog[$];
  int  hi, lo, abort_hi, done_cnt;
  bit  done_busy, done_prev_busy, prev_busy;

  always @(posedge clk) begin
    if (rst) begin
      hi = 0;
      lo = 0;
    end else begin
      if (valid) begin
        hi++;
        if (ready) begin
          wr_t e;
          e.addr = int'(address);
          e.data = int'(wdata);
          e.hi   = hi;
          e.lo   = lo;
          wlog.push_back(e);
          hi = 0;
          lo = 0;
        end
      end else begin
        if (hi != 0) abort_hi = hi;
        hi = 0;
        lo++;
      end
      if (done) begin
        done_cnt++;
        done_busy      = busy;
        done_prev_busy = prev_busy;
      end
    end
    prev_busy = busy;
  end

  int n_assert, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input int a, input int d, input int h);
    if (i < wlog.size()) begin
      chk({tag, "_addr"}, wlog[i].addr, a);
      chk({tag, "_data"}, wlog[i].data, d);
      chk({tag, "_hi"}, wlog[i].hi, h);
    end else begin
      chk({tag, "_missing"}, wlog.size(), i + 1);
    end
  endtask

  task automatic chk_gap(input string tag, input int i, input int g);
    if (i < wlog.size()) chk(tag, wlog[i].lo, g);
    else chk({tag, "_missing"}, wlog.size(), i + 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wlog.delete();
    done_cnt  = 0;
    abort_hi  = 0;
    done_busy = 1'b1;
    done_prev_busy = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit p, input logic [15:0] cc);
    @(negedge clk);
    start = s;
    pwrdn = p;
    charge_cycles = cc;
    @(negedge clk);
    start = 1'b0;
    pwrdn = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
    tick(2);
  endtask

  task automatic run_pu(input string tag, input logic [15:0] cc, input int gap, input int lim);
    clear_log();
    pulse(1'b1, 1'b0, cc);
    wait_idle(tag, lim);
    chk({tag, "_nwr"}, wlog.size(), 3);
    chk_gap({tag, "_gap_chg"}, 2, gap);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    slave_dead = 1'b0;
    start = 1'b0;
    pwrdn = 1'b0;
    charge_cycles = '0;
    rst = 1'b1;
    tick(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_wstrb", wstrb, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", address, 1'b0);
    chk("rst_wdata", wdata, 32'h0);
    rst = 1'b0;
    tick(2);

    // Nominal power-up, 10 charge cycles
    clear_log();
    pulse(1'b1, 1'b0, 16'd10);
    chk("nom_busy", busy, 1'b1);
    wait_idle("nom", 200);
    chk("nom_nwr", wlog.size(), 3);
    chk_wr("nom_w0", 0, 0, 0, 2);
    chk_wr("nom_w1", 1, 1, 1, 2);
    chk_wr("nom_w2", 2, 1, 0, 2);
    chk_gap("nom_gap1", 1, 1);
    chk_gap("nom_gap2", 2, 10);
    chk("nom_done_cnt", done_cnt, 1);
    chk("nom_done_busy", done_busy, 1'b0);
    chk("nom_done_prev_busy", done_prev_busy, 1'b1);
    chk("nom_pd", s_pd, 1'b0);
    chk("nom_chg", s_chg, 1'b0);

    // Charge-count edges
    run_pu("cc0", 16'd0, 1, 200);
    run_pu("cc1", 16'd1, 1, 200);
    run_pu("ccmax", 16'hFFFF, 65535, 70000);

    // Power-down from IDLE
    clear_log();
    pulse(1'b0, 1'b1, 16'd0);
    wait_idle("pd", 200);
    chk("pd_nwr", wlog.size(), 2);
    chk_wr("pd_w0", 0, 1, 0, 2);
    chk_wr("pd_w1", 1, 0, 1, 2);
    chk_gap("pd_gap", 1, 1);
    chk("pd_pd", s_pd, 1'b1);
    chk("pd_done_cnt", done_cnt, 1);

    // pwrdn wins over start in the same cycle
    clear_log();
    pulse(1'b1, 1'b1, 16'd5);
    wait_idle("both", 200);
    chk("both_nwr", wlog.size(), 2);
    chk_wr("both_w0", 0, 1, 0, 2);
    chk_wr("both_w1", 1, 0, 1, 2);
    chk("both_done_cnt", done_cnt, 1);

    // Pre-emption of power-up during CHG_WAIT
    clear_log();
    pulse(1'b1, 1'b0, 16'd100);
    begin
      int n = 0;
      while (wlog.size() < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("pre_chg1_seen", wlog.size(), 2);
    tick(2);
    pulse(1'b0, 1'b1, 16'd100);
    wait_idle("pre", 400);
    chk("pre_nwr", wlog.size(), 4);
    chk_wr("pre_w2", 2, 1, 0, 2);
    chk_wr("pre_w3", 3, 0, 1, 2);
    if (wlog.size() > 2) chk("pre_latency", (wlog[2].lo >= 3 && wlog[2].lo <= 4), 1'b1);
    chk("pre_done_cnt", done_cnt, 1);
    chk("pre_pd", s_pd, 1'b1);

    // start while busy is ignored
    clear_log();
    pulse(1'b1, 1'b0, 16'd5);
    tick(3);
    pulse(1'b1, 1'b0, 16'd9);
    wait_idle("sbusy", 200);
    chk("sbusy_nwr", wlog.size(), 3);
    chk_gap("sbusy_gap", 2, 5);
    chk("sbusy_done_cnt", done_cnt, 1);

    // Timeout against a dead slave
    clear_log();
    slave_dead = 1'b1;
    pulse(1'b1, 1'b0, 16'd4);
    wait_idle("to", 200);
    chk("to_valid_hi", abort_hi, 64);
    chk("to_valid", valid, 1'b0);
    chk("to_err", err, 1'b1);
    chk("to_done_cnt", done_cnt, 0);
    chk("to_nwr", wlog.size(), 0);
    tick(5);
    chk("to_err_sticky", err, 1'b1);

    // Recovery start clears err
    clear_log();
    slave_dead = 1'b0;
    pulse(1'b1, 1'b0, 16'd2);
    chk("rec_err_clr", err, 1'b0);
    wait_idle("rec", 200);
    chk("rec_nwr", wlog.size(), 3);
    chk("rec_done_cnt", done_cnt, 1);
    chk("rec_err", err, 1'b0);

    // Reset in the middle of the CHG1 write
    clear_log();
    pulse(1'b1, 1'b0, 16'd3);
    begin
      int n = 0;
      while (!(valid && address == 1'b1) && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mr_in_chg1", {valid, wdata[0]}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_valid", valid, 1'b0);
    chk("mr_wstrb", wstrb, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0);
    chk("mr_err", err, 1'b0);
    chk("mr_addr", address, 1'b0);
    chk("mr_wdata", wdata, 32'h0);
    rst = 1'b0;
    tick(10);
    chk("mr_idle_busy", busy, 1'b0);
    chk("mr_idle_valid", valid, 1'b0);
    chk("mr_nwr", wlog.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/iref_seq.md
Name: iref_seq

Overview:
- Bus initiator that drives the IREF current-reference peripheral's CPU-side slave port (valid/address/wdata/wstrb/ready) to run power-up and power-down sequences in hardware.
- Power-up: clear PD, pulse CHARGE for a programmable number of cycles, then clear CHARGE.
- Power-down: clear CHARGE, set PD.
- Sits in the WSN-EM power-management path beside the CPU; its bus is muxed onto the IREF slave port.

Parameters:
- DATA_W, 32, bus data width.
- IREF_ADDR_W, 1, IREF register address width; PD at address 0, CHARGE at address 1.
- CNT_W, 16, width of the charge_cycles input and the charge counter.
- TIMEOUT_CYC, 64, maximum cycles valid may stay high without ready before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse: run the power-up sequence
- pwrdn  in  1  single-cycle pulse: run the power-down sequence
- charge_cycles  in  CNT_W  CHARGE pulse length in cycles, sampled at start
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful sequence completion
- err  out  1  sticky timeout flag
- valid  out  1  bus request
- address  out  IREF_ADDR_W  target register
- wdata  out  DATA_W  write data; bit 0 = value, other bits 0
- wstrb  out  1  write strobe; equals valid
- ready  in  1  bus acknowledge from the IREF slave

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs registered; on rst they go to 0 at the next edge and the FSM goes to IDLE. This applies mid-transaction too: valid drops and the write is not completed.
- States: IDLE, WR, GAP, CHG_WAIT, DONE, ERR.
- Each WR state carries a step tag: PD0, CHG1, CHG0, PD1.
- Sequences:
  - Power-up = PD0 -> GAP -> CHG1 -> CHG_WAIT -> CHG0 -> DONE.
  - Power-down = CHG0 -> GAP -> PD1 -> DONE.
- Write handshake:
  - In WR, valid=wstrb=1; address and wdata are held stable.
  - Transfer completes on the edge where ready=1 is sampled while valid=1. At that edge valid is cleared.
  - ready is ignored whenever valid=0.
  - Against the IREF slave (ready registered one cycle after valid), valid is high for exactly 2 cycles per write.
- Inter-write gap:
  - After every completed write, valid stays low for at least 1 cycle (GAP), so the slave's ready returns low before the next request.
  - CHG_WAIT holds valid low for max(charge_cycles,1) cycles, then enters WR CHG0.
  - The counter is loaded from the value sampled at start and decrements to 1.
- Timeout:
  - A per-write counter increments each cycle valid=1 and ready=0.
  - When it reaches TIMEOUT_CYC: valid <= 0, state ERR, err <= 1, busy <= 0.
  - err is sticky until the next accepted start/pwrdn or rst. No done pulse on error.
- done and busy:
  - In DONE, done=1 for one cycle, busy <= 0, then IDLE.
  - busy is 1 from the edge after an accepted request until the DONE/ERR edge.
- Request arbitration:
  - start or pwrdn is accepted only in IDLE or ERR. If both are asserted in the same cycle, pwrdn wins.
  - start while busy is ignored.
  - pwrdn while executing power-up is latched (pend_pd). At the next GAP or CHG_WAIT cycle the FSM abandons power-up and enters the power-down sequence (CHG0, GAP, PD1), then DONE.
  - pwrdn during power-down is ignored.
  - An in-flight write is always completed or timed out, never dropped, except by rst.
- wdata values: PD0 -> address 0, wdata 0. CHG1 -> address 1, wdata 1. CHG0 -> address 1, wdata 0. PD1 -> address 0, wdata 1.

Test Plan:
- Nominal power-up:
  - Stimulus: model IREF slave, charge_cycles=10, start pulse.
  - Required response: writes (addr0,0), (addr1,1), (addr1,0) in order, each with valid high 2 cycles; 1 low cycle after the first write; exactly 10 low cycles between the CHG1 and CHG0 writes; done pulses once; busy falls the same edge; slave pd=0, charge=0.
- Edge charge counts:
  - Stimulus: charge_cycles=0, then charge_cycles=1.
  - Required response: both give exactly 1 valid-low cycle between CHG1 and CHG0.
  - Stimulus: charge_cycles=16'hFFFF.
  - Required response: 65535 low cycles.
- Power-down:
  - Stimulus: pwrdn from IDLE.
  - Required response: writes (addr1,0) then (addr0,1); slave pd=1; done pulse.
  - Stimulus: pwrdn and start asserted in the same cycle.
  - Required response: identical power-down only.
- Pre-emption:
  - Stimulus: pwrdn 3 cycles into CHG_WAIT, charge_cycles=100.
  - Required response: within 1 cycle valid rises for (addr1,0), then (addr0,1); no further CHG1 write; a single done pulse.
  - Stimulus: start while busy.
  - Required response: no extra writes.
- Timeout:
  - Stimulus: slave holds ready=0, TIMEOUT_CYC=64.
  - Required response: valid high exactly 64 cycles then 0; err=1; busy=0; no done.
  - Stimulus: a following start with a working slave.
  - Required response: err clears and the sequence completes.
- Reset mid-write:
  - Stimulus: rst asserted during the CHG1 write.
  - Required response: next edge valid=wstrb=busy=done=err=0 and address=wdata=0; the FSM stays idle until a new start.
